// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: bus widths, byte-mask codes, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package dmem_bridge_pkg;

    localparam int BUS_DW = 64;          // bus data width in bits
    localparam int BUS_SW = BUS_DW / 8;  // strobe width, one bit per byte lane
    localparam int BUS_AW = 64;          // byte address width

    // Low-justified access-size masks driven by the core.
    localparam logic [BUS_SW-1:0] BYTES_B = 8'h01;
    localparam logic [BUS_SW-1:0] BYTES_H = 8'h03;
    localparam logic [BUS_SW-1:0] BYTES_W = 8'h0F;
    localparam logic [BUS_SW-1:0] BYTES_D = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Number of bytes covered by a mask. The legal codes decode directly;
    // anything else falls back to a plain bit count.
    function automatic logic [3:0] mask_size(input logic [BUS_SW-1:0] m);
        logic [3:0] n;
        n = 4'd0;
        case (m)
            BYTES_B: n = 4'd1;
            BYTES_H: n = 4'd2;
            BYTES_W: n = 4'd4;
            BYTES_D: n = 4'd8;
            default: begin
                for (int i = 0; i < BUS_SW; i++) begin
                    n = n + {3'b000, m[i]};
                end
            end
        endcase
        return n;
    endfunction

    // Expand a byte mask into a bit mask over the data word.
    function automatic logic [BUS_DW-1:0] lane_mask(input logic [BUS_SW-1:0] m);
        logic [BUS_DW-1:0] bm;
        bm = '0;
        for (int i = 0; i < BUS_SW; i++) begin
            bm[8*i +: 8] = {8{m[i]}};
        end
        return bm;
    endfunction

endpackage

// File: rtl/dmem_bridge_lane_align.sv
// Byte-lane steering between the core's low-justified view and the 8-byte bus word.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
import dmem_bridge_pkg::*;

module dmem_lane_align (
    input  logic [2:0]        offset_i,
    input  logic [BUS_SW-1:0] bytes_i,
    input  logic [BUS_DW-1:0] wdata_i,
    input  logic [BUS_DW-1:0] rdata_raw_i,
    output logic [BUS_SW-1:0] strb_o,
    output logic [BUS_DW-1:0] wdata_aligned_o,
    output logic [BUS_DW-1:0] rdata_justified_o,
    output logic              misaligned_o
);

    logic [5:0] bit_shift;

    assign bit_shift = {offset_i, 3'b000};

    // Strobe bits that would shift past lane 7 are dropped; such an access is
    // flagged misaligned instead of being split.
    assign strb_o            = bytes_i << offset_i;
    assign misaligned_o      = (({1'b0, offset_i} + mask_size(bytes_i)) > 4'd8);
    assign wdata_aligned_o   = wdata_i << bit_shift;
    assign rdata_justified_o = (rdata_raw_i >> bit_shift) & lane_mask(bytes_i);

endmodule

// File: rtl/dmem_bridge.sv
// Core data-access port to registered valid/ready memory bus bridge, one access in flight.
// Latency: 4 cycles per access minimum (stall high 3), misaligned aborts after 1 cycle.
// Backpressure: request held stable while bus_ready=0; stall held until response or timeout.
import dmem_bridge_pkg::*;

module dmem_bridge #(
    parameter int TIMEOUT = 256,  // cycles allowed in REQ+RESP, at least 4
    parameter int CNT_W   = 9     // must be able to hold TIMEOUT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              acs_en,
    input  logic              acs_wr,
    input  logic [BUS_SW-1:0] acs_bytes,
    input  logic [BUS_AW-1:0] acs_addr,
    input  logic [BUS_DW-1:0] acs_wdata,
    output logic [BUS_DW-1:0] acs_rdata,
    output logic              stall,
    output logic              err,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [BUS_AW-1:0] bus_addr,
    output logic [BUS_SW-1:0] bus_strb,
    output logic [BUS_DW-1:0] bus_wdata,
    input  logic              bus_rvalid,
    input  logic [BUS_DW-1:0] bus_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        off_q, off_d;
    logic [BUS_SW-1:0] bytes_q, bytes_d;
    logic              bus_valid_q, bus_valid_d;
    logic              bus_we_q, bus_we_d;
    logic [BUS_AW-1:0] bus_addr_q, bus_addr_d;
    logic [BUS_SW-1:0] bus_strb_q, bus_strb_d;
    logic [BUS_DW-1:0] bus_wdata_q, bus_wdata_d;
    logic [BUS_DW-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [2:0]        la_off;
    logic [BUS_SW-1:0] la_bytes;
    logic [BUS_SW-1:0] la_strb;
    logic [BUS_DW-1:0] la_wdata;
    logic [BUS_DW-1:0] la_rdata;
    logic              la_mis;

    // Access fields come straight from the core only in IDLE; afterwards the
    // copies latched at issue steer the response lanes.
    always_comb begin
        la_off   = off_q;
        la_bytes = bytes_q;
        if (state_q == ST_IDLE) begin
            la_off   = acs_addr[2:0];
            la_bytes = acs_bytes;
        end
    end

    dmem_lane_align u_lane_align (
        .offset_i          (la_off),
        .bytes_i           (la_bytes),
        .wdata_i           (acs_wdata),
        .rdata_raw_i       (bus_rdata),
        .strb_o            (la_strb),
        .wdata_aligned_o   (la_wdata),
        .rdata_justified_o (la_rdata),
        .misaligned_o      (la_mis)
    );

    // Next-state, timeout counter and registered bus/response fields.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        bytes_d     = bytes_q;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_strb_d  = bus_strb_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (acs_en) begin
                    off_d   = acs_addr[2:0];
                    bytes_d = acs_bytes;
                    if (la_mis) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        bus_valid_d = 1'b1;
                        bus_we_d    = acs_wr;
                        bus_addr_d  = {acs_addr[BUS_AW-1:3], 3'b000};
                        bus_strb_d  = la_strb;
                        bus_wdata_d = la_wdata;
                        cnt_d       = '0;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_ONE;
                // Timeout takes priority: the access is abandoned even if the
                // slave happens to accept in the very last cycle.
                if (cnt_q == CNT_LAST) begin
                    bus_valid_d = 1'b0;
                    err_d       = 1'b1;
                    rdata_d     = '0;
                    state_d     = ST_DONE;
                end else if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                cnt_d = cnt_q + CNT_ONE;
                // A response in the last allowed cycle still completes normally.
                if (bus_rvalid) begin
                    if (!bus_we_q) begin
                        rdata_d = la_rdata;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Always pass through IDLE so a still-asserted acs_en is not
                // mistaken for a fresh access.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            off_q       <= '0;
            bytes_q     <= '0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_strb_q  <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            bytes_q     <= bytes_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_strb_q  <= bus_strb_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign stall     = acs_en & (state_q != ST_DONE);
    assign err       = err_q;
    assign acs_rdata = rdata_q;
    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_strb  = bus_strb_q;
    assign bus_wdata = bus_wdata_q;

endmodule
